sccb_req_arbiter: RTL and testbench

//  Shares the single SCCB write master between N register-write requesters: the power-up init

---
 rtl/sccb_req_arbiter_pkg.sv | 15 +
 rtl/sccb_req_arbiter_if.sv | 25 ++
 rtl/sccb_rr_picker.sv | 29 ++
 rtl/sccb_req_arbiter.sv | 110 +++++++++++
 tb/tb_sccb_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_req_arbiter_pkg.sv
// Shared types and OV7670 register constants for the SCCB write-request arbiter.
package sccb_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  localparam logic [7:0] OV7670_COM7_ADDR    = 8'h12;
  localparam int         OV7670_COM7_RST_BIT = 7;
  localparam logic [7:0] OV7670_WR_ID        = 8'h42;

  // COM7 with the reset bit set restarts the sensor and needs the long idle gap.
  function automatic logic is_soft_reset(input logic [7:0] regi, input logic [7:0] value);
    return (regi == OV7670_COM7_ADDR) && value[OV7670_COM7_RST_BIT];
  endfunction

endpackage

// File: rtl/sccb_req_arbiter_if.sv
// Requester-side and SCCB-master-side signals of the arbiter; slave = arbiter, master = environment.
interface sccb_req_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] regi;
  logic [8*N_REQ-1:0] value;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   err;
  logic               busy;
  logic               sccb_send;
  logic [7:0]         sccb_regi;
  logic [7:0]         sccb_value;
  logic               sccb_taken;

  modport slave (
    input  req, regi, value, sccb_taken,
    output ack, err, busy, sccb_send, sccb_regi, sccb_value
  );

  modport master (
    output req, regi, value, sccb_taken,
    input  ack, err, busy, sccb_send, sccb_regi, sccb_value
  );
endinterface

// File: rtl/sccb_rr_picker.sv
// Round-robin winner over requesters 1..N_REQ-1, scanning upward from ptr with wrap to 1.
// Purely combinational; also returns the pointer to use after granting the winner.
module sccb_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:1] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    winner,
  output logic [IW-1:0]    next_ptr
);
  logic [IW-1:0] idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    next_ptr = ptr;
    idx      = '0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      idx = IW'(((int'(ptr) - 1 + k) % (N_REQ - 1)) + 1);
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = idx;
        next_ptr = (int'(idx) == N_REQ - 1) ? IW'(1) : IW'(int'(idx) + 1);
      end
    end
  end
endmodule

// File: rtl/sccb_req_arbiter.sv
// Shares one SCCB write master among N_REQ requesters (port 0 strict priority, rest round-robin).
// Grant to send high takes 2 cycles; requests are sampled only in IDLE, after the post-write gap.
module sccb_req_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = 25000,
  parameter int RST_GAP_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic               clk_i,
  input logic               rst_i,
  sccb_req_arbiter_if.slave bus
);
  localparam int IW     = $clog2(N_REQ);
  localparam int MAX_A  = (GAP_CYCLES > RST_GAP_CYCLES) ? GAP_CYCLES : RST_GAP_CYCLES;
  localparam int MAX_P  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW_RAW = $clog2(MAX_P) + 1;
  localparam int CW     = (CW_RAW < 20) ? 20 : CW_RAW;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, owner, rr_winner, rr_next, grant_idx;
  logic             rr_found, any_req, taken_hit, timeout_hit, gap_done;
  logic [CW-1:0]    cnt, gap_limit;
  logic             send_q;
  logic [7:0]       regi_q, value_q;
  logic [N_REQ-1:0] ack_q, err_q;

  sccb_rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req      (bus.req[N_REQ-1:1]),
    .ptr      (ptr),
    .found    (rr_found),
    .winner   (rr_winner),
    .next_ptr (rr_next)
  );

  assign any_req     = bus.req[0] | rr_found;
  assign grant_idx   = bus.req[0] ? '0 : rr_winner;
  assign gap_limit   = is_soft_reset(regi_q, value_q) ? CW'(RST_GAP_CYCLES - 1) : CW'(GAP_CYCLES - 1);
  // taken is checked first below, so a coincident timeout still completes as an ack
  assign taken_hit   = (state == S_ISSUE) && bus.sccb_taken;
  assign timeout_hit = (state == S_ISSUE) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign gap_done    = (state == S_GAP) && (cnt == gap_limit);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: if (taken_hit || timeout_hit) state_nxt = S_GAP;
      S_GAP:   if (gap_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      ptr     <= IW'(1);
      owner   <= '0;
      cnt     <= '0;
      send_q  <= 1'b0;
      regi_q  <= '0;
      value_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= '0;
      err_q <= '0;
      case (state)
        S_IDLE: begin
          cnt    <= '0;
          send_q <= 1'b0;
          if (any_req) begin
            owner   <= grant_idx;
            regi_q  <= bus.regi[{grant_idx, 3'b000} +: 8];
            value_q <= bus.value[{grant_idx, 3'b000} +: 8];
            if (!bus.req[0]) ptr <= rr_next;
          end
        end
        S_ISSUE: begin
          if (taken_hit) begin
            send_q       <= 1'b0;
            ack_q[owner] <= 1'b1;
            cnt          <= '0;
          end else if (timeout_hit) begin
            send_q       <= 1'b0;
            err_q[owner] <= 1'b1;
            cnt          <= '0;
          end else begin
            send_q <= 1'b1;
            cnt    <= cnt + 1'b1;
          end
        end
        S_GAP: cnt <= gap_done ? '0 : cnt + 1'b1;
        default: begin
          send_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.sccb_send  = send_q;
  assign bus.sccb_regi  = regi_q;
  assign bus.sccb_value = value_q;
  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Randomized and directed bench for sccb_req_arbiter with a queue-based grant-order model and scoreboard.
module tb_sccb_req_arbiter;
  localparam int N    = 4;
  localparam int GAP  = 20;
  localparam int RGAP = 60;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_req_arbiter_if #(.N_REQ(N)) bus ();

  sccb_req_arbiter #(
    .N_REQ(N), .GAP_CYCLES(GAP), .RST_GAP_CYCLES(RGAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct { logic [7:0] regi; logic [7:0] value; } wr_t;
  typedef struct { int port; logic [7:0] regi; logic [7:0] value; bit is_err; int gap; } exp_t;

  wr_t  pq [N][$];
  exp_t exp_q [$];
  int   dly_of [logic [15:0]];
  int   tests = 0;
  int   fails = 0;
  int   mptr = 1;
  bit   rst_zone = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add(input int p, input logic [7:0] r, input logic [7:0] v, input int d);
    wr_t w;
    w.regi = r; w.value = v;
    pq[p].push_back(w);
    dly_of[{r, v}] = d;
  endtask

  task automatic add_rand(input int p);
    logic [7:0] r, v;
    int sel, d;
    do begin
      r = 8'($urandom);
      v = 8'($urandom);
      if ($urandom_range(4, 0) == 0) r = 8'h12;
    end while (dly_of.exists({r, v}));
    sel = $urandom_range(9, 0);
    d = (sel == 0) ? TMO + 50 : (sel == 1) ? TMO - 1 : $urandom_range(40, 1);
    add(p, r, v, d);
  endtask

  // Reference: all pending requests are held from one IDLE cycle until drained, so the service
  // order is port 0 first, then a circular scan over 1..N-1 starting at the rotating pointer.
  task automatic model_predict();
    int   left [N];
    int   pos  [N];
    int   w, total;
    exp_t e;
    for (int i = 0; i < N; i++) begin left[i] = pq[i].size(); pos[i] = 0; end
    while (1) begin
      total = 0;
      for (int i = 0; i < N; i++) total += left[i];
      if (total == 0) break;
      if (left[0] > 0) w = 0;
      else begin
        w = mptr;
        while (left[w] == 0) w = (w == N - 1) ? 1 : w + 1;
        mptr = (w == N - 1) ? 1 : w + 1;
      end
      e.port   = w;
      e.regi   = pq[w][pos[w]].regi;
      e.value  = pq[w][pos[w]].value;
      e.is_err = dly_of[{e.regi, e.value}] > TMO - 1;
      e.gap    = (e.regi == 8'h12 && e.value[7]) ? RGAP : GAP;
      exp_q.push_back(e);
      pos[w]++;
      left[w]--;
    end
  endtask

  task automatic drop_owner();
    for (int i = 0; i < N; i++)
      if (pq[i].size() == 1 && pq[i][0].regi == bus.sccb_regi && pq[i][0].value == bus.sccb_value)
        bus.req[i] = 1'b0;
  endtask

  task automatic run_scn(input bit early);
    int n;
    bit prev;
    model_predict();
    for (int i = 0; i < N; i++)
      if (pq[i].size() > 0) begin
        bus.regi[8*i +: 8]  = pq[i][0].regi;
        bus.value[8*i +: 8] = pq[i][0].value;
        bus.req[i] = 1'b1;
      end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.sccb_send && n < 10);
    chk("grant_latency", n, 2);
    if (early) drop_owner();
    n = 0;
    prev = 1'b1;
    while (!(all_empty() && !bus.busy) && n < 20000) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++)
        if ((bus.ack[i] || bus.err[i]) && pq[i].size() > 0) begin
          pq[i].delete(0);
          if (pq[i].size() > 0) begin
            bus.regi[8*i +: 8]  = pq[i][0].regi;
            bus.value[8*i +: 8] = pq[i][0].value;
          end else bus.req[i] = 1'b0;
        end
      if (early && bus.sccb_send && !prev) drop_owner();
      prev = bus.sccb_send;
    end
    chk("scenario_complete", int'(n < 20000), 1);
  endtask

  task automatic rand_scn();
    int np = 0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(1, 0) == 1) begin
        np++;
        repeat ($urandom_range(2, 1)) add_rand(i);
      end
    if (np == 0) add_rand(1);
    run_scn(1'($urandom_range(1, 0)));
  endtask

  // SCCB master stand-in: pulses taken during the D-th cycle that send is high, D looked up per write.
  initial begin
    int hi, d;
    bit resp_gap;
    hi = 0; d = 1; resp_gap = 1'b0;
    bus.sccb_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (|(bus.ack | bus.err)) resp_gap = 1'b1;
      if (!bus.busy) resp_gap = 1'b0;
      if (bus.sccb_send) begin
        hi++;
        if (hi == 1) d = dly_of.exists({bus.sccb_regi, bus.sccb_value}) ? dly_of[{bus.sccb_regi, bus.sccb_value}] : 1;
        bus.sccb_taken = (hi == d);
      end else begin
        hi = 0;
        bus.sccb_taken = (resp_gap || !bus.busy) && ($urandom_range(5, 0) == 0);
      end
    end
  end

  // Scoreboard monitor: every ack/err pulse pops one expected write and checks it and its gap.
  initial begin
    exp_t e;
    bit cap, stable, gap_on, gap_send;
    logic [7:0] cap_r, cap_v;
    int gap_n, gap_exp, p;
    cap = 0; stable = 1; gap_on = 0; gap_send = 0; gap_n = 0; gap_exp = 0; cap_r = 0; cap_v = 0;
    forever begin
      @(negedge clk);
      if (rst_zone) begin cap = 0; gap_on = 0; end
      if (bus.sccb_send && !cap) begin
        cap = 1; stable = 1; cap_r = bus.sccb_regi; cap_v = bus.sccb_value;
      end else if (bus.sccb_send && (bus.sccb_regi != cap_r || bus.sccb_value != cap_v)) stable = 0;
      if (|(bus.ack | bus.err)) begin
        chk("pulse_onehot", $countones(bus.ack | bus.err), 1);
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = exp_q.pop_front();
          p = -1;
          for (int i = 0; i < N; i++) if (bus.ack[i] || bus.err[i]) p = i;
          chk("grant_port", p, e.port);
          chk("err_vs_ack", int'(|bus.err), int'(e.is_err));
          chk("send_seen", int'(cap), 1);
          chk("bus_regi", int'(cap_r), int'(e.regi));
          chk("bus_value", int'(cap_v), int'(e.value));
          chk("bus_stable", int'(stable), 1);
          chk("send_drop_at_pulse", int'(bus.sccb_send), 0);
          gap_on = 1; gap_n = 1; gap_exp = e.gap; gap_send = 0;
        end
        cap = 0;
      end else if (gap_on) begin
        if (bus.busy) begin
          gap_n++;
          if (bus.sccb_send) gap_send = 1;
        end else begin
          chk("gap_len", gap_n, gap_exp);
          chk("send_in_gap", int'(gap_send), 0);
          gap_on = 0;
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    fails++;
    $display("FAIL watchdog: cycle budget exhausted");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.req = '0; bus.regi = '0; bus.value = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_send", int'(bus.sccb_send), 0);
    chk("rst_regi", int'(bus.sccb_regi), 0);
    chk("rst_value", int'(bus.sccb_value), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    rst_zone = 1'b0;
    repeat (2) @(negedge clk);

    add(1, 8'h13, 8'hE5, 30);                               run_scn(0);
    add(0, 8'h3A, 8'h04, 7);   add(2, 8'h6B, 8'h0A, 12);   run_scn(1);
    add(1, 8'h10, 8'h20, 5);   add(1, 8'h10, 8'h21, 9);
    add(2, 8'h00, 8'h01, 3);   add(2, 8'h00, 8'h02, 15);   run_scn(0);
    add(1, 8'h12, 8'h80, 4);   add(1, 8'h12, 8'h04, 6);    run_scn(0);
    add(2, 8'h20, 8'h11, 1000);                             run_scn(0);
    add(3, 8'h21, 8'h22, TMO - 1);                          run_scn(0);
    add(1, 8'h23, 8'h24, TMO);                              run_scn(0);
    repeat (8) rand_scn();

    // Reset in the middle of a write: nothing may be acknowledged and the pointer returns to 1.
    add(2, 8'h30, 8'h31, 1000);
    bus.regi[16 +: 8] = 8'h30; bus.value[16 +: 8] = 8'h31; bus.req[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.sccb_send && n < 10);
    chk("rst_test_send_up", int'(bus.sccb_send), 1);
    repeat (3) @(negedge clk);
    rst_zone = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_send", int'(bus.sccb_send), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    rst = 1'b0;
    bus.req[2] = 1'b0;
    pq[2].delete();
    mptr = 1;
    repeat (6) @(negedge clk);
    rst_zone = 1'b0;

    add(1, 8'h40, 8'h01, 2);   add(1, 8'h40, 8'h02, 3);
    add(2, 8'h41, 8'h01, 4);   add(3, 8'h42, 8'h01, 5);    run_scn(0);

    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
